// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - request/response bundle between the CPU memory port and memory_responder
// MEM_STATS_EN adds the rd_count/wr_count statistics signals.
interface memory_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  Read;
  logic                  Write;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  mem_busy;
  logic                  mem_done;
  logic                  mem_err;
`ifdef MEM_STATS_EN
  logic [15:0]           rd_count;
  logic [15:0]           wr_count;
`endif

  modport master (
    output mem_addr, Read, Write, mem_wdata,
    input  Mdatain, mem_busy, mem_done, mem_err
`ifdef MEM_STATS_EN
    , input rd_count, wr_count
`endif
  );

  modport slave (
    input  mem_addr, Read, Write, mem_wdata,
    output Mdatain, mem_busy, mem_done, mem_err
`ifdef MEM_STATS_EN
    , output rd_count, wr_count
`endif
  );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency single-port word RAM responder for the CPU memory interface
// Optional MEM_STATS_EN adds saturating completed-read/write counters.
module memory_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic              clock,
  input  logic              clear,
  memory_responder_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] ram [0:(1<<ADDR_WIDTH)-1];

  logic accept;
  logic finish;

  assign accept = (state == ST_IDLE) && (bus.Read ^ bus.Write);
  assign finish = (state == ST_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == ST_IDLE) && bus.Read && bus.Write;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_addr  <= bus.mem_addr;
            lat_wdata <= bus.mem_wdata;
            lat_write <= bus.Write;
            cnt       <= CNT_LOAD;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!lat_write) rdata_q <= ram[lat_addr];
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM is left unreset; an aborted write never reaches finish because reset forces IDLE.
  always_ff @(posedge clock) begin
    if (finish && lat_write) ram[lat_addr] <= lat_wdata;
  end

  assign bus.Mdatain  = rdata_q;
  assign bus.mem_busy = (state != ST_IDLE);
  assign bus.mem_done = (state == ST_DONE);
  assign bus.mem_err  = err_q;

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (finish) begin
      if (lat_write && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!lat_write && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign bus.rd_count = rd_cnt_q;
  assign bus.wr_count = wr_cnt_q;
`endif
endmodule
